// File: rtl/control_sequencer_if.sv
// Control sequencer bus: step enable, instruction/flag inputs from the
// datapath, and the control word plus status returned by the sequencer.
interface control_sequencer_if;
  logic        ena;
  logic [3:0]  opcode;
  logic        flag_c;
  logic        flag_z;
  logic [14:0] control_signals;
  logic [2:0]  t_state;
  logic        halted;

  // Driver side: the instruction/ALU side that steps the sequencer.
  modport master (
    output ena, opcode, flag_c, flag_z,
    input  control_signals, t_state, halted
  );

  // Sequencer side.
  modport slave (
    input  ena, opcode, flag_c, flag_z,
    output control_signals, t_state, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// Micro-step sequencer for an 8-bit accumulator CPU: three fetch steps
// followed by up to three execute steps, emitting a 15-bit control word.
// Optional conditional jumps (JC/JZ) are built when CTRL_SEQ_JCOND_EN is
// defined; otherwise opcodes 0x7/0x8 behave as NOPs and the flags are unused.
//
// state | meaning
// ------+---------------------------------------------------------------
// T0    | fetch: PC onto bus, load MAR
// T1    | fetch: increment PC
// T2    | fetch: RAM onto bus, load IR
// T3    | execute 1: decode live opcode, latch it
// T4    | execute 2: decode latched opcode (LDA/ADD/SUB/STA)
// T5    | execute 3: ALU result into A (ADD/SUB)
// HALT  | clock stopped; left only through rst
module control_sequencer (
  input  logic                 clk,
  input  logic                 rst,
  control_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_HALT = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
`ifdef CTRL_SEQ_JCOND_EN
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
`endif

  // Single-bit masks; active-high signals are OR'd in, active-low ones
  // (n-prefixed) are cleared from the idle word.
  localparam logic [14:0] B_CP  = 15'h4000;
  localparam logic [14:0] B_EP  = 15'h2000;
  localparam logic [14:0] B_LP  = 15'h1000;
  localparam logic [14:0] B_NLM = 15'h0800;
  localparam logic [14:0] B_NCE = 15'h0400;
  localparam logic [14:0] B_NLI = 15'h0200;
  localparam logic [14:0] B_NEI = 15'h0100;
  localparam logic [14:0] B_NLA = 15'h0080;
  localparam logic [14:0] B_NLB = 15'h0040;
  localparam logic [14:0] B_NLO = 15'h0020;
  localparam logic [14:0] B_EA  = 15'h0010;
  localparam logic [14:0] B_SU  = 15'h0008;
  localparam logic [14:0] B_EU  = 15'h0004;
  localparam logic [14:0] B_NLR = 15'h0002;
  localparam logic [14:0] B_NHLT = 15'h0001;

  localparam logic [14:0] W_IDLE    = 15'h0FE3;
  localparam logic [14:0] W_T0      = (W_IDLE | B_EP) & ~B_NLM;
  localparam logic [14:0] W_T1      = W_IDLE | B_CP;
  localparam logic [14:0] W_T2      = W_IDLE & ~(B_NCE | B_NLI);
  localparam logic [14:0] W_T3_MEM  = W_IDLE & ~(B_NEI | B_NLM);
  localparam logic [14:0] W_LDA_T4  = W_IDLE & ~(B_NCE | B_NLA);
  localparam logic [14:0] W_ALU_T4  = W_IDLE & ~(B_NCE | B_NLB);
  localparam logic [14:0] W_ADD_T5  = (W_IDLE | B_EU) & ~B_NLA;
  localparam logic [14:0] W_SUB_T5  = (W_IDLE | B_EU | B_SU) & ~B_NLA;
  localparam logic [14:0] W_STA_T4  = (W_IDLE | B_EA) & ~B_NLR;
  localparam logic [14:0] W_LDI_T3  = W_IDLE & ~(B_NEI | B_NLA);
  localparam logic [14:0] W_JMP_T3  = (W_IDLE | B_LP) & ~B_NEI;
  localparam logic [14:0] W_OUT_T3  = (W_IDLE | B_EA) & ~B_NLO;
  localparam logic [14:0] W_HLT     = W_IDLE & ~B_NHLT;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  opcode_q;
  logic [3:0]  opcode_d;
  logic [14:0] ctrl_word;

  // State and latched opcode; rst wins over ena and every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_T0;
      opcode_q <= 4'h0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Next-state and control-word decode; ena low freezes everything and
  // forces the inactive word (HALT keeps its halt word).
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    ctrl_word = W_IDLE;

    case (state_q)
      ST_T0: begin
        ctrl_word = W_T0;
        state_d   = ST_T1;
      end
      ST_T1: begin
        ctrl_word = W_T1;
        state_d   = ST_T2;
      end
      ST_T2: begin
        ctrl_word = W_T2;
        state_d   = ST_T3;
      end
      ST_T3: begin
        opcode_d = bus.opcode;
        state_d  = ST_T0;
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl_word = W_T3_MEM;
            state_d   = ST_T4;
          end
          OP_LDI: ctrl_word = W_LDI_T3;
          OP_JMP: ctrl_word = W_JMP_T3;
          OP_OUT: ctrl_word = W_OUT_T3;
          OP_HLT: begin
            ctrl_word = W_HLT;
            state_d   = ST_HALT;
          end
`ifdef CTRL_SEQ_JCOND_EN
          OP_JC:  ctrl_word = bus.flag_c ? W_JMP_T3 : W_IDLE;
          OP_JZ:  ctrl_word = bus.flag_z ? W_JMP_T3 : W_IDLE;
`endif
          default: ctrl_word = W_IDLE;
        endcase
      end
      ST_T4: begin
        state_d = ST_T0;
        case (opcode_q)
          OP_LDA: ctrl_word = W_LDA_T4;
          OP_ADD, OP_SUB: begin
            ctrl_word = W_ALU_T4;
            state_d   = ST_T5;
          end
          OP_STA: ctrl_word = W_STA_T4;
          default: ctrl_word = W_IDLE;
        endcase
      end
      ST_T5: begin
        state_d = ST_T0;
        case (opcode_q)
          OP_ADD:  ctrl_word = W_ADD_T5;
          OP_SUB:  ctrl_word = W_SUB_T5;
          default: ctrl_word = W_IDLE;
        endcase
      end
      ST_HALT: begin
        ctrl_word = W_HLT;
        state_d   = ST_HALT;
      end
      default: begin
        ctrl_word = W_IDLE;
        state_d   = ST_T0;
      end
    endcase

    if (!bus.ena) begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      ctrl_word = (state_q == ST_HALT) ? W_HLT : W_IDLE;
    end
  end

`ifndef CTRL_SEQ_JCOND_EN
  logic unused_flags;
  assign unused_flags = bus.flag_c ^ bus.flag_z;
`endif

  assign bus.control_signals = ctrl_word;
  assign bus.t_state         = state_q;
  assign bus.halted          = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboarded bench for control_sequencer: each driven cycle pushes the
// expected status/word, and the negedge monitor pops and compares.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  control_sequencer_if bus_if ();

  control_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [2:0]  t_state;
    logic        halted;
    logic [14:0] word;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs just after the edge and record what the
  // outputs must be for that cycle.
  task automatic step(input logic r, input logic e, input logic [3:0] op,
                      input logic fc, input logic fz,
                      input logic [2:0] et, input logic eh, input logic [14:0] ew,
                      input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    rst           = r;
    bus_if.ena    = e;
    bus_if.opcode = op;
    bus_if.flag_c = fc;
    bus_if.flag_z = fz;
    x.tag = tag; x.t_state = et; x.halted = eh; x.word = ew;
    exp_q.push_back(x);
  endtask

  task automatic fetch(input logic [3:0] op, input string tag);
    step(0, 1, op, 0, 0, 3'd0, 0, 15'h27E3, {tag, ".t0"});
    step(0, 1, op, 0, 0, 3'd1, 0, 15'h4FE3, {tag, ".t1"});
    step(0, 1, op, 0, 0, 3'd2, 0, 15'h09E3, {tag, ".t2"});
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.tag, ".word"}, 32'(bus_if.control_signals), 32'(mon_e.word));
      check({mon_e.tag, ".t"},    32'(bus_if.t_state),         32'(mon_e.t_state));
      check({mon_e.tag, ".halt"}, 32'(bus_if.halted),          32'(mon_e.halted));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [14:0] jz1_word;
    logic [14:0] jc1_word;
`ifdef CTRL_SEQ_JCOND_EN
    jz1_word = 15'h1EE3;
    jc1_word = 15'h1EE3;
`else
    jz1_word = 15'h0FE3;
    jc1_word = 15'h0FE3;
`endif
    bus_if.ena = 1'b0; bus_if.opcode = 4'h0; bus_if.flag_c = 1'b0; bus_if.flag_z = 1'b0;
    @(posedge clk);
    #1;

    // LDI: three fetch steps, one execute step, back to T0.
    fetch(4'h4, "ldi");
    step(0, 1, 4'h4, 0, 0, 3'd3, 0, 15'h0E63, "ldi.t3");

    // ADD with opcode changed during T4/T5: latched opcode drives decode.
    fetch(4'h1, "add");
    step(0, 1, 4'h1, 0, 0, 3'd3, 0, 15'h06E3, "add.t3");
    step(0, 1, 4'h0, 0, 0, 3'd4, 0, 15'h0BA3, "add.t4");
    step(0, 1, 4'h0, 0, 0, 3'd5, 0, 15'h0F67, "add.t5");

    // SUB, same shape with SU in T5.
    fetch(4'h2, "sub");
    step(0, 1, 4'h2, 0, 0, 3'd3, 0, 15'h06E3, "sub.t3");
    step(0, 1, 4'h0, 0, 0, 3'd4, 0, 15'h0BA3, "sub.t4");
    step(0, 1, 4'h0, 0, 0, 3'd5, 0, 15'h0F6F, "sub.t5");

    // LDA with ena low for three cycles in T4.
    fetch(4'h0, "lda");
    step(0, 1, 4'h0, 0, 0, 3'd3, 0, 15'h06E3, "lda.t3");
    for (int i = 0; i < 3; i++)
      step(0, 0, 4'h5, 0, 0, 3'd4, 0, 15'h0FE3, "lda.hold");
    step(0, 1, 4'h5, 0, 0, 3'd4, 0, 15'h0B63, "lda.t4");

    // STA, then ena low in T0.
    fetch(4'h3, "sta");
    step(0, 1, 4'h3, 0, 0, 3'd3, 0, 15'h06E3, "sta.t3");
    step(0, 1, 4'h3, 0, 0, 3'd4, 0, 15'h0FF1, "sta.t4");
    step(0, 0, 4'h3, 0, 0, 3'd0, 0, 15'h0FE3, "hold.t0");

    // Single-step opcodes and a NOP.
    fetch(4'h5, "jmp");
    step(0, 1, 4'h5, 0, 0, 3'd3, 0, 15'h1EE3, "jmp.t3");
    fetch(4'hE, "out");
    step(0, 1, 4'hE, 0, 0, 3'd3, 0, 15'h0FD3, "out.t3");
    fetch(4'h9, "nop");
    step(0, 1, 4'h9, 1, 1, 3'd3, 0, 15'h0FE3, "nop.t3");

    // Conditional jumps; each must look only at its own flag.
    fetch(4'h8, "jz1");
    step(0, 1, 4'h8, 0, 1, 3'd3, 0, jz1_word, "jz1.t3");
    fetch(4'h8, "jz0");
    step(0, 1, 4'h8, 1, 0, 3'd3, 0, 15'h0FE3, "jz0.t3");
    fetch(4'h7, "jc1");
    step(0, 1, 4'h7, 1, 0, 3'd3, 0, jc1_word, "jc1.t3");
    fetch(4'h7, "jc0");
    step(0, 1, 4'h7, 0, 1, 3'd3, 0, 15'h0FE3, "jc0.t3");

    // rst during T5 of ADD.
    fetch(4'h1, "addr");
    step(0, 1, 4'h1, 0, 0, 3'd3, 0, 15'h06E3, "addr.t3");
    step(0, 1, 4'h1, 0, 0, 3'd4, 0, 15'h0BA3, "addr.t4");
    step(1, 1, 4'h1, 0, 0, 3'd5, 0, 15'h0F67, "addr.t5");
    step(0, 1, 4'h1, 0, 0, 3'd0, 0, 15'h27E3, "addr.post");
    step(0, 1, 4'h1, 0, 0, 3'd1, 0, 15'h4FE3, "addr.t1");
    step(0, 1, 4'h1, 0, 0, 3'd2, 0, 15'h09E3, "addr.t2");

    // HLT: halt word in T3, then HALT held for 20 cycles regardless of inputs.
    step(0, 1, 4'hF, 0, 0, 3'd3, 0, 15'h0FE2, "hlt.t3");
    for (int i = 0; i < 20; i++)
      step(0, (i % 3) != 0, 4'(i), 1, 1, 3'd7, 1, 15'h0FE2, "halt.hold");
    step(1, 1, 4'h0, 0, 0, 3'd7, 1, 15'h0FE2, "halt.rst");
    step(0, 1, 4'h0, 0, 0, 3'd0, 0, 15'h27E3, "halt.post");
    step(0, 1, 4'h0, 0, 0, 3'd1, 0, 15'h4FE3, "halt.t1");

    @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 ena  input  1  step enable; when low, sequencer holds state.
REQ-005 opcode  input  4  instruction register upper nibble; valid from T3.
REQ-006 flag_c  input  1  ALU carry flag; used only when CTRL_SEQ_JCOND_EN is defined.
REQ-007 flag_z  input  1  ALU zero flag; used only when CTRL_SEQ_JCOND_EN is defined.
REQ-008 control_signals  output  15  control word driven to the datapath.
REQ-009 t_state  output  3  current micro-step: 0-5 for T0-T5, 7 for HALT.
REQ-010 halted  output  1  high while in HALT.

Function
REQ-011 Control word bit map SHALL be:
- 14 CP (high)
- 13 EP (high)
- 12 LP (high)
- 11 nLM
- 10 nCE
- 9 nLI
- 8 nEI
- 7 nLA
- 6 nLB
- 5 nLO
- 4 EA (high)
- 3 SU (high)
- 2 EU (high)
- 1 nLR
- 0 nHLT
REQ-012 The idle word (all signals inactive) SHALL be 15'h0FE3; each micro-step SHALL assert only its listed signals on top of it.
REQ-013 FSM states SHALL be T0, T1, T2, T3, T4, T5 and HALT; each state lasts exactly one cycle with ena high.
REQ-014 Fetch steps SHALL be:
- T0: EP, nLM (15'h27E3)
- T1: CP (15'h4FE3)
- T2: nCE, nLI (15'h09E3)
REQ-015 T3 SHALL decode the live opcode and latch it; T4 and T5 SHALL decode the latched opcode.
REQ-016 Execute steps, after which the FSM returns to T0, SHALL be:
- LDA 0x0: T3 nEI,nLM; T4 nCE,nLA
- ADD 0x1: T3 nEI,nLM; T4 nCE,nLB; T5 EU,nLA
- SUB 0x2: as ADD with SU added in T5
- STA 0x3: T3 nEI,nLM; T4 EA,nLR
- LDI 0x4: T3 nEI,nLA
- JMP 0x5: T3 nEI,LP
- OUT 0xE: T3 EA,nLO
REQ-017 HLT 0xF: T3 SHALL output 15'h0FE2 and the next state SHALL be HALT.
REQ-018 HALT SHALL output 15'h0FE2 with halted=1 and t_state=7, and SHALL be left only by rst.
REQ-019 Undefined opcodes SHALL execute as a NOP: T3 outputs the idle word, then the FSM returns to T0.
REQ-020 With ena low, state and latched opcode SHALL hold and control_signals SHALL be 15'h0FE3. In HALT, control_signals SHALL stay 15'h0FE2.
REQ-021 control_signals SHALL be a combinational decode of state and opcode, with no added latency.
REQ-022 rst SHALL take priority over ena and every state.

Reset
REQ-023 On a clock edge with rst high, the FSM SHALL enter T0 and clear halted and the latched opcode, from any state including HALT or mid-execute.
REQ-024 After reset: t_state=0, halted=0, control_signals=15'h27E3.

Configuration
REQ-025 When CTRL_SEQ_JCOND_EN is defined:
- JC 0x7 SHALL output T3 nEI,LP (15'h1EE3) if flag_c=1, else the idle word.
- JZ 0x8 SHALL do the same using flag_z.
- Both SHALL then return to T0.
REQ-026 When CTRL_SEQ_JCOND_EN is undefined, 0x7 and 0x8 SHALL be NOPs, and flag_c and flag_z SHALL be ignored.

Verification
REQ-027 Reset then LDI (0x4), ena=1 -> T0..T3 words 27E3, 4FE3, 09E3, 0E63; T0 again on the 5th cycle.
REQ-028 ADD (0x1) with opcode changed to 0x0 during T4 -> T5 = 0F67 (latched opcode used); SUB gives T5 = 0F6F.
REQ-029 HLT (0xF) -> T3 = 0FE2, then halted=1, t_state=7 held for 20 cycles; rst -> 27E3, halted=0.
REQ-030 ena low during T4 of LDA for 3 cycles -> 0FE3 and t_state=4 held; on resume T4 = 0B63.
REQ-031 rst asserted in T5 of ADD -> next cycle t_state=0, 27E3.
REQ-032 With CTRL_SEQ_JCOND_EN: JZ with flag_z=1 -> T3 = 1EE3; flag_z=0 -> T3 = 0FE3. Without the macro -> T3 = 0FE3 in both cases.
